// File: rtl/matmul_apb_fabric_if.sv
`default_nettype none
// ============================================================================
// Module  : matmul_apb_fabric_if
// Brief   : Upstream APB slave port plus NSLAVES-wide downstream APB fan-out.
// Revision: 1.0 - initial release
// ============================================================================
interface matmul_apb_fabric_if #(
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int NSLAVES    = 4,
    parameter int SEL_WIDTH  = (NSLAVES > 1) ? $clog2(NSLAVES) : 1
);
    logic                           psel_i;
    logic                           penable_i;
    logic                           pwrite_i;
    logic [BUS_WIDTH/8-1:0]         pstrb_i;
    logic [BUS_WIDTH-1:0]           pwdata_i;
    logic [ADDR_WIDTH+SEL_WIDTH-1:0] paddr_i;
    logic                           pready_o;
    logic                           pslverr_o;
    logic [BUS_WIDTH-1:0]           prdata_o;

    logic [NSLAVES-1:0]             m_psel_o;
    logic                           m_penable_o;
    logic                           m_pwrite_o;
    logic [BUS_WIDTH/8-1:0]         m_pstrb_o;
    logic [BUS_WIDTH-1:0]           m_pwdata_o;
    logic [ADDR_WIDTH-1:0]          m_paddr_o;
    logic [NSLAVES-1:0]             m_pready_i;
    logic [NSLAVES-1:0]             m_pslverr_i;
    logic [NSLAVES*BUS_WIDTH-1:0]   m_prdata_i;

    // Fabric side
    modport slave (
        input  psel_i, penable_i, pwrite_i, pstrb_i, pwdata_i, paddr_i,
        output pready_o, pslverr_o, prdata_o,
        output m_psel_o, m_penable_o, m_pwrite_o, m_pstrb_o, m_pwdata_o, m_paddr_o,
        input  m_pready_i, m_pslverr_i, m_prdata_i
    );

    // Environment side: upstream master and the downstream accelerators
    modport master (
        output psel_i, penable_i, pwrite_i, pstrb_i, pwdata_i, paddr_i,
        input  pready_o, pslverr_o, prdata_o,
        input  m_psel_o, m_penable_o, m_pwrite_o, m_pstrb_o, m_pwdata_o, m_paddr_o,
        output m_pready_i, m_pslverr_i, m_prdata_i
    );
endinterface
`default_nettype wire

// File: rtl/matmul_apb_fabric.sv
`default_nettype none
// ============================================================================
// Module  : matmul_apb_fabric
// Brief   : APB 1:NSLAVES fan-out to matmul accelerators with busy aggregation.
//           Optional downstream timeout enabled by defining APB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module matmul_apb_fabric #(
    parameter int BUS_WIDTH   = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int NSLAVES     = 4,
    parameter int SEL_WIDTH   = (NSLAVES > 1) ? $clog2(NSLAVES) : 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  wire logic               clk_i,
    input  wire logic               rst_n_i,
    matmul_apb_fabric_if.slave      bus,
    input  wire logic [NSLAVES-1:0] busy_i,
    output logic      [NSLAVES-1:0] busy_vec_o,
    output logic                    busy_o
);
    localparam int c_STRB_W = BUS_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DSETUP  = 3'd1,
        S_DACCESS = 3'd2,
        S_RESP    = 3'd3,
        S_ERR     = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [SEL_WIDTH-1:0]   r_idx;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [BUS_WIDTH-1:0]   r_wdata;
    logic [c_STRB_W-1:0]    r_strb;
    logic                   r_write;
    logic [BUS_WIDTH-1:0]   r_rdata;
    logic                   r_slverr;

    logic [SEL_WIDTH-1:0]   w_req_idx;
    logic                   w_req_bad;
    logic                   w_setup;
    logic                   w_active;
    logic                   w_sel_ready;
    logic                   w_sel_err;
    logic [BUS_WIDTH-1:0]   w_sel_rdata;
    logic                   w_timeout;

    assign w_req_idx = bus.paddr_i[ADDR_WIDTH+SEL_WIDTH-1:ADDR_WIDTH];
    assign w_req_bad = (32'(w_req_idx) >= NSLAVES);
    assign w_setup   = bus.psel_i & ~bus.penable_i;
    assign w_active  = (r_state == S_DSETUP) || (r_state == S_DACCESS);

    // Response mux for the selected accelerator only
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_err   = 1'b0;
        w_sel_rdata = '0;
        for (int k = 0; k < NSLAVES; k++) begin
            if (r_idx == SEL_WIDTH'(k)) begin
                w_sel_ready = bus.m_pready_i[k];
                w_sel_err   = bus.m_pslverr_i[k];
                w_sel_rdata = bus.m_prdata_i[k*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [c_CNT_W-1:0] r_wait_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_DSETUP) begin
            r_wait_cnt <= '0;
        end else if ((r_state == S_DACCESS) && !w_sel_ready) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Fires on the TIMEOUT_CYC-th consecutive not-ready access cycle
    assign w_timeout = (r_state == S_DACCESS) && !w_sel_ready &&
                       (r_wait_cnt == c_CNT_W'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_setup) w_next = w_req_bad ? S_ERR : S_DSETUP;
            S_DSETUP:  w_next = S_DACCESS;
            S_DACCESS: if (w_sel_ready || w_timeout) w_next = S_RESP;
            S_RESP:    w_next = S_IDLE;
            S_ERR:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_strb   <= '0;
            r_write  <= 1'b0;
            r_rdata  <= '0;
            r_slverr <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && w_setup) begin
                r_idx   <= w_req_idx;
                r_addr  <= bus.paddr_i[ADDR_WIDTH-1:0];
                r_wdata <= bus.pwdata_i;
                r_strb  <= bus.pstrb_i;
                r_write <= bus.pwrite_i;
            end
            if ((r_state == S_DACCESS) && w_sel_ready) begin
                r_slverr <= w_sel_err;
                r_rdata  <= r_write ? '0 : w_sel_rdata;
            end else if (w_timeout) begin
                r_slverr <= 1'b1;
                r_rdata  <= '0;
            end
        end
    end

    // Downstream port is decoded from registered state so reset clears it at once
    assign bus.m_psel_o    = w_active ? (NSLAVES'(1) << r_idx) : '0;
    assign bus.m_penable_o = (r_state == S_DACCESS);
    assign bus.m_pwrite_o  = w_active & r_write;
    assign bus.m_pstrb_o   = (w_active && r_write) ? r_strb : '0;
    assign bus.m_pwdata_o  = w_active ? r_wdata : '0;
    assign bus.m_paddr_o   = w_active ? r_addr : '0;

    assign bus.pready_o    = (r_state == S_RESP) || (r_state == S_ERR);
    assign bus.pslverr_o   = (r_state == S_ERR) || ((r_state == S_RESP) && r_slverr);
    assign bus.prdata_o    = (r_state == S_RESP) ? r_rdata : '0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_vec_o <= '0;
            busy_o     <= 1'b0;
        end else begin
            busy_vec_o <= busy_i;
            busy_o     <= |busy_i;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_matmul_apb_fabric.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_matmul_apb_fabric
// Brief   : Vector table + scoreboard bench for matmul_apb_fabric.
// Revision: 1.0 - initial release
// ============================================================================
module tb_matmul_apb_fabric;
    localparam int BW  = 32;
    localparam int AW  = 16;
    localparam int NS  = 4;
    localparam int NS3 = 3;
`ifdef APB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NS-1:0]  busy_in;
    logic [NS-1:0]  busy_vec;
    logic           busy;
    logic [NS3-1:0] busy3_in;
    logic [NS3-1:0] busy3_vec;
    logic           busy3;

    matmul_apb_fabric_if #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .NSLAVES(NS))  bus ();
    matmul_apb_fabric_if #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .NSLAVES(NS3)) bus3 ();

    matmul_apb_fabric #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .NSLAVES(NS), .TIMEOUT_CYC(TO)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .bus(bus),
        .busy_i(busy_in), .busy_vec_o(busy_vec), .busy_o(busy)
    );

    matmul_apb_fabric #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .NSLAVES(NS3), .TIMEOUT_CYC(TO)) u_dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .bus(bus3),
        .busy_i(busy3_in), .busy_vec_o(busy3_vec), .busy_o(busy3)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  slv;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic [31:0] srdata;
        logic        serr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    vec_t vecs[6];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive_slaves(input logic [1:0] slv, input logic rdy,
                                input logic [31:0] rdata, input logic err);
        // Unselected slaves look ready/erroring so a wrong response mux shows up
        bus.m_pready_i  = ~(NS'(1) << slv);
        bus.m_pslverr_i = ~(NS'(1) << slv);
        for (int k = 0; k < NS; k++) bus.m_prdata_i[k*BW +: BW] = 32'hEEEE_0000 | k;
        if (rdy) begin
            bus.m_pready_i[slv]          = 1'b1;
            bus.m_pslverr_i[slv]         = err;
            bus.m_prdata_i[slv*BW +: BW] = rdata;
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {bus.pready_o, bus.pslverr_o, bus.prdata_o, bus.m_psel_o, bus.m_penable_o,
                bus.m_pwrite_o, bus.m_pstrb_o, bus.m_pwdata_o, bus.m_paddr_o, busy, busy_vec};
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        int   acc = 0;
        bit   done = 0;
        bit   saw_sel = 0;
        bit   proto_bad = 0;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        e.lat   = v.exp_lat;
        exp_q.push_back(e);
        bus.psel_i    = 1'b1;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = v.wr;
        bus.paddr_i   = {v.slv, v.addr};
        bus.pwdata_i  = v.wdata;
        bus.pstrb_i   = v.strb;
        drive_slaves(v.slv, 1'b0, 32'h0, 1'b0);
        for (int n = 0; n < 40; n++) begin
            if (n == 1) bus.penable_i = 1'b1;
            if ($countones(bus.m_psel_o) > 1) proto_bad = 1;
            if (bus.m_penable_o && bus.m_psel_o == '0) proto_bad = 1;
            if (!v.wr && bus.m_pstrb_o != '0) proto_bad = 1;
            if (bus.m_psel_o != '0 && !saw_sel) begin
                saw_sel = 1;
                check({tag, "_dsetup"},
                      {bus.m_psel_o, bus.m_paddr_o, bus.m_pwrite_o, bus.m_pstrb_o,
                       (v.wr ? bus.m_pwdata_o : 32'h0)},
                      {NS'(1) << v.slv, v.addr, v.wr, (v.wr ? v.strb : 4'h0),
                       (v.wr ? v.wdata : 32'h0)});
            end
            if (bus.pready_o) begin
                e = exp_q.pop_front();
                check({tag, "_lat"}, n, e.lat);
                check({tag, "_prdata"}, bus.prdata_o, e.rdata);
                check({tag, "_pslverr"}, bus.pslverr_o, e.err);
                done = 1;
                break;
            end
            if (bus.m_penable_o && bus.m_psel_o[v.slv]) begin
                drive_slaves(v.slv, (acc >= v.waits), v.srdata, v.serr);
                acc++;
            end else begin
                drive_slaves(v.slv, 1'b0, 32'h0, 1'b0);
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            void'(exp_q.pop_front());
            check({tag, "_no_pready"}, 0, 1);
        end
        check({tag, "_protocol"}, {proto_bad, saw_sel}, 2'b01);
        @(posedge clk); #1;
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        drive_slaves(2'd0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        int cnt;
        bit seen;
        vecs[0] = '{1'b1, 2'd2, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 32'h55AA55AA, 1'b0, 32'h0,        1'b0, 3};
        vecs[1] = '{1'b0, 2'd1, 16'h0040, 32'hFFFFFFFF, 4'hF, 3, 32'h12345678, 1'b0, 32'h12345678, 1'b0, 6};
        vecs[2] = '{1'b1, 2'd3, 16'h0100, 32'h0BADF00D, 4'h5, 0, 32'h77777777, 1'b1, 32'h0,        1'b1, 3};
        vecs[3] = '{1'b0, 2'd0, 16'hFFFC, 32'h0,        4'h0, 1, 32'hA5A50F0F, 1'b0, 32'hA5A50F0F, 1'b0, 4};
        vecs[4] = '{1'b0, 2'd3, 16'h0008, 32'h0,        4'hF, 2, 32'h00001111, 1'b1, 32'h00001111, 1'b1, 5};
        vecs[5] = '{1'b1, 2'd1, 16'h0004, 32'hCAFEBABE, 4'h3, 1, 32'h0,        1'b0, 32'h0,        1'b0, 4};

        bus.psel_i = 0; bus.penable_i = 0; bus.pwrite_i = 0; bus.pstrb_i = 0;
        bus.pwdata_i = 0; bus.paddr_i = 0;
        drive_slaves(2'd0, 1'b0, 32'h0, 1'b0);
        bus3.psel_i = 0; bus3.penable_i = 0; bus3.pwrite_i = 0; bus3.pstrb_i = 0;
        bus3.pwdata_i = 0; bus3.paddr_i = 0;
        bus3.m_pready_i = 0; bus3.m_pslverr_i = 0; bus3.m_prdata_i = 0;
        busy_in = 0; busy3_in = 0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", all_outs(), 128'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Decode error on the 3-slave instance: index 3 is out of range
        bus3.psel_i = 1'b1; bus3.penable_i = 1'b0; bus3.pwrite_i = 1'b0;
        bus3.paddr_i = {2'd3, 16'h0020};
        check("dec_t0", {bus3.pready_o, bus3.m_psel_o}, 0);
        @(posedge clk); #1;
        bus3.penable_i = 1'b1;
        check("dec_resp", {bus3.pready_o, bus3.pslverr_o, bus3.prdata_o}, {1'b1, 1'b1, 32'h0});
        check("dec_msel", {bus3.m_psel_o, bus3.m_penable_o}, 0);
        @(posedge clk); #1;
        bus3.psel_i = 1'b0; bus3.penable_i = 1'b0;
        check("dec_idle", {bus3.pready_o, bus3.m_psel_o}, 0);

        // Busy aggregation, one-cycle latency
        busy_in = 4'b1000;
        check("busy_pre", {busy, busy_vec}, 5'b0);
        @(posedge clk); #1;
        check("busy_set", {busy, busy_vec}, 5'b1_1000);
        busy_in = 4'b0000;
        @(posedge clk); #1;
        check("busy_clr", {busy, busy_vec}, 5'b0);

        // Asynchronous reset during the downstream access phase
        bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
        bus.paddr_i = {2'd2, 16'h0ABC}; bus.pstrb_i = 4'hF;
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            if (n == 1) bus.penable_i = 1'b1;
            if (bus.m_penable_o) begin seen = 1; break; end
            @(posedge clk); #1;
        end
        check("rst_reached_access", seen, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("rst_async_clear", all_outs(), 128'h0);
        @(posedge clk); #1;
        bus.psel_i = 1'b0; bus.penable_i = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(vecs[0], "post_rst");

        // Hung slave 0
        bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
        bus.paddr_i = {2'd0, 16'h0030};
        drive_slaves(2'd0, 1'b0, 32'h0, 1'b0);
`ifdef APB_TIMEOUT_EN
        cnt = 0; seen = 0;
        for (int n = 0; n < 60; n++) begin
            if (n == 1) bus.penable_i = 1'b1;
            if (bus.pready_o) begin
                seen = 1;
                check("to_access_cycles", cnt, 8);
                check("to_resp", {bus.pslverr_o, bus.prdata_o, bus.m_psel_o, bus.m_penable_o},
                      {1'b1, 32'h0, 4'h0, 1'b0});
                break;
            end
            if (bus.m_penable_o) cnt++;
            @(posedge clk); #1;
        end
        if (!seen) check("to_no_pready", 0, 1);
        drive_slaves(2'd0, 1'b1, 32'h99, 1'b0);
        @(posedge clk); #1;
        check("to_late_ready", {bus.pready_o, bus.m_psel_o}, 0);
        bus.psel_i = 1'b0; bus.penable_i = 1'b0;
        drive_slaves(2'd0, 1'b0, 32'h0, 1'b0);
        @(posedge clk); #1;
`else
        @(posedge clk); #1;
        bus.penable_i = 1'b1;
        repeat (1000) @(posedge clk);
        #1;
        check("hang_pending", {bus.pready_o, bus.m_penable_o, bus.m_psel_o}, {1'b0, 1'b1, 4'b0001});
        rst_n = 1'b0;
        #1 check("hang_rst_clear", {bus.m_psel_o, bus.m_penable_o}, 0);
        bus.psel_i = 1'b0; bus.penable_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
`endif
        run_vec(vecs[1], "post_hang");

        check("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
`default_nettype wire
